// File: rtl/servo_pwm_array.sv
// Multi-channel 50 Hz servo PWM generator with per-frame slew limiting.
// Position and enable changes are applied only at frame boundaries, so pulses are never cut short or stretched.
module servo_pwm_array #(
    parameter int CHANNELS  = 2,
    parameter int VAL_W     = 10,
    parameter int CLK_HZ    = 100_000_000,
    parameter int FRAME_US  = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int SLEW_STEP = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*VAL_W-1:0] val,
    input  logic [CHANNELS-1:0]       val_valid,
    input  logic                      enable,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      frame_start
);

    localparam int TICKS  = CLK_HZ / 1_000_000;
    localparam int PS_W   = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int US_W   = $clog2(FRAME_US);
    localparam int WU_W   = $clog2(MAX_US + 1);
    localparam int RANGE  = MAX_US - MIN_US;
    localparam int PROD_W = VAL_W + $clog2(RANGE + 1);

    localparam logic [VAL_W-1:0] CENTRE   = VAL_W'(1) << (VAL_W - 1);
    localparam logic [WU_W-1:0]  CENTRE_W = WU_W'(MIN_US + RANGE / 2);

    logic [PS_W-1:0]     r_presc;
    logic [US_W-1:0]     r_us_cnt;
    logic                r_first;
    logic                r_en_frame;
    logic [CHANNELS-1:0] r_pwm;
    logic                r_frame_start;

    logic                w_tick;
    logic                w_boundary;
    logic [PS_W-1:0]     w_presc_next;
    logic [US_W-1:0]     w_us_next;
    logic                w_en_next;
    logic [CHANNELS-1:0] w_pwm_next;

    // r_first forces a boundary on the first edge after reset so a frame starts immediately.
    assign w_tick       = (r_presc == PS_W'(TICKS - 1));
    assign w_boundary   = r_first || (w_tick && (r_us_cnt == US_W'(FRAME_US - 1)));
    assign w_presc_next = (w_boundary || w_tick) ? '0 : r_presc + 1'b1;
    assign w_us_next    = w_boundary ? '0 : (w_tick ? r_us_cnt + 1'b1 : r_us_cnt);
    assign w_en_next    = w_boundary ? enable : r_en_frame;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc       <= '0;
            r_us_cnt      <= '0;
            r_first       <= 1'b1;
            r_en_frame    <= 1'b0;
            r_pwm         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_presc       <= w_presc_next;
            r_us_cnt      <= w_us_next;
            r_first       <= 1'b0;
            r_en_frame    <= w_en_next;
            r_pwm         <= w_pwm_next;
            r_frame_start <= w_boundary;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [VAL_W-1:0]  r_target;
            logic [VAL_W-1:0]  r_pos;
            logic [WU_W-1:0]   r_width_us;
            logic [VAL_W-1:0]  w_pos_next;
            logic [PROD_W-1:0] w_prod;
            logic [PROD_W-1:0] w_scaled;
            logic [WU_W-1:0]   w_width_next;

            if (SLEW_STEP == 0) begin : g_direct
                assign w_pos_next = r_target;
            end else begin : g_slew
                // Step toward the target, landing exactly on it once within one step.
                always_comb begin
                    w_pos_next = r_target;
                    if (r_target > r_pos) begin
                        if (32'(r_target - r_pos) > SLEW_STEP)
                            w_pos_next = r_pos + VAL_W'(SLEW_STEP);
                    end else if (32'(r_pos - r_target) > SLEW_STEP) begin
                        w_pos_next = r_pos - VAL_W'(SLEW_STEP);
                    end
                end
            end

            assign w_prod       = PROD_W'(w_pos_next) * PROD_W'(RANGE);
            assign w_scaled     = w_prod >> VAL_W;
            assign w_width_next = w_boundary ? WU_W'(MIN_US) + WU_W'(w_scaled) : r_width_us;
            assign w_pwm_next[gi] = w_en_next && (32'(w_us_next) < 32'(w_width_next));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_target   <= CENTRE;
                    r_pos      <= CENTRE;
                    r_width_us <= CENTRE_W;
                end else begin
                    if (val_valid[gi])
                        r_target <= val[gi*VAL_W +: VAL_W];
                    if (w_boundary)
                        r_pos <= w_pos_next;
                    r_width_us <= w_width_next;
                end
            end
        end
    endgenerate

    assign pwm         = r_pwm;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_servo_pwm_array.sv
// Scoreboard bench: two instances (direct and slew-limited) on scaled-down timing; one frame = 600 cycles.
module tb_servo_pwm_array;

    localparam int CH        = 2;
    localparam int VW        = 10;
    localparam int FRAME_CYC = 600;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b1;
    logic [CH*VW-1:0] val_a = '0, val_b = '0;
    logic [CH-1:0]   vv_a = '0, vv_b = '0;
    logic [CH-1:0]   pwm_a, pwm_b;
    logic            fs_a, fs_b;

    always #5 clk = ~clk;

    servo_pwm_array #(.CHANNELS(CH), .VAL_W(VW), .CLK_HZ(2_000_000), .FRAME_US(300),
                      .MIN_US(100), .MAX_US(200), .SLEW_STEP(0)) u_direct (
        .clk(clk), .rst(rst), .val(val_a), .val_valid(vv_a), .enable(enable),
        .pwm(pwm_a), .frame_start(fs_a));

    servo_pwm_array #(.CHANNELS(CH), .VAL_W(VW), .CLK_HZ(2_000_000), .FRAME_US(300),
                      .MIN_US(100), .MAX_US(200), .SLEW_STEP(100)) u_slew (
        .clk(clk), .rst(rst), .val(val_b), .val_valid(vv_b), .enable(enable),
        .pwm(pwm_b), .frame_start(fs_b));

    typedef struct { int a0; int a1; int b0; int b1; } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int a0, input int a1, input int b0, input int b1);
        exp_t e;
        e.a0 = a0; e.a1 = a1; e.b0 = b0; e.b1 = b1;
        exp_q.push_back(e);
    endtask

    task automatic wait_fs();
        bit seen = 1'b0;
        for (int i = 0; i < 2 * FRAME_CYC && !seen; i++) begin
            @(negedge clk);
            if (fs_a) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL wait_frame_start: none within %0d cycles", 2 * FRAME_CYC);
        end
    endtask

    // Monitor: measures each complete frame and checks it against the queued expectation.
    bit started = 1'b0;
    int len = 0;
    int frame_no = 0;
    int hi[4];
    bit fell[4];
    bit glitch[4];

    always @(negedge clk) begin
        logic [3:0] obs;
        obs = {pwm_b, pwm_a};
        if (!rst) begin
            started = 1'b0;
        end else begin
            if (fs_a) begin
                if (started) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_frame %0d: got a frame, expected none", frame_no);
                    end else begin
                        exp_t e;
                        int req[4];
                        e = exp_q.pop_front();
                        req = '{e.a0, e.a1, e.b0, e.b1};
                        chk($sformatf("frame%0d_len", frame_no), len, FRAME_CYC);
                        for (int c = 0; c < 4; c++) begin
                            chk($sformatf("frame%0d_width_%s%0d", frame_no, (c < 2) ? "a" : "b", c % 2), hi[c], req[c]);
                            chk($sformatf("frame%0d_single_pulse_%0d", frame_no, c), int'(glitch[c]), 0);
                        end
                        $display("frame %0d: len=%0d widths a=%0d/%0d b=%0d/%0d", frame_no, len,
                                 hi[0], hi[1], hi[2], hi[3]);
                    end
                    frame_no++;
                end
                chk("fs_b_aligned", int'(fs_b), 1);
                started = 1'b1;
                len = 0;
                for (int c = 0; c < 4; c++) begin
                    hi[c] = 0; fell[c] = 1'b0; glitch[c] = 1'b0;
                end
            end
            if (started) begin
                len++;
                for (int c = 0; c < 4; c++) begin
                    if (obs[c]) begin
                        if (fell[c]) glitch[c] = 1'b1;
                        hi[c]++;
                    end else begin
                        fell[c] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pwm_a", int'(pwm_a), 0);
        chk("reset_pwm_b", int'(pwm_b), 0);
        chk("reset_frame_start", int'(fs_a), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("first_frame_start", int'(fs_a), 1);

        // F0: centre width; strobe mid-frame must not affect this frame
        wait_fs(); push(300, 300, 300, 300);
        repeat (100) @(posedge clk);
        #1 val_a = {10'd1023, 10'd0}; val_b = {10'd1023, 10'd0}; vv_a = 2'b11; vv_b = 2'b11;
        @(posedge clk);
        #1 vv_a = '0; vv_b = '0;

        wait_fs(); push(200, 398, 280, 318);   // F1
        wait_fs(); push(200, 398, 260, 338);   // F2
        wait_fs(); push(200, 398, 240, 358);   // F3

        // Strobe coinciding with the boundary edge into F4
        repeat (FRAME_CYC - 1) @(posedge clk);
        #1 val_a = {10'd512, 10'd1023}; vv_a = 2'b11;
        @(posedge clk);
        #1 vv_a = '0;
        chk("boundary_strobe_frame_start", int'(fs_a), 1);

        wait_fs(); push(200, 398, 220, 378);   // F4: still previous targets
        wait_fs(); push(398, 300, 202, 396);   // F5: enable dropped mid-pulse
        repeat (100) @(posedge clk);
        #1 enable = 1'b0;
        wait_fs(); push(0, 0, 0, 0);           // F6: disabled
        repeat (100) @(posedge clk);
        #1 enable = 1'b1;

        // F7: reset in the middle of the pulses
        wait_fs();
        repeat (50) @(posedge clk);
        #3;
        chk("pre_reset_pwm_a", int'(pwm_a), 3);
        chk("pre_reset_pwm_b", int'(pwm_b), 3);
        rst = 1'b0;
        #1;
        chk("async_reset_pwm_a", int'(pwm_a), 0);
        chk("async_reset_pwm_b", int'(pwm_b), 0);
        chk("async_reset_frame_start", int'(fs_a), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_frame_start", int'(fs_a), 1);

        wait_fs(); push(300, 300, 300, 300);   // F8: recentred
        wait_fs(); push(300, 300, 300, 300);   // F9

        for (int i = 0; i < 3 * FRAME_CYC && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain: %0d frames unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
